// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix row scanner with double-buffered frame memory,
// per-row blanking and 4-bit PWM column dimming.
module led_matrix_scanner #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned ROW_CYCLES     = 65536,
    parameter int unsigned BLANK_CYCLES   = 64,
    parameter bit          ROW_ACTIVE_LOW = 1'b1,
    parameter bit          COL_ACTIVE_LOW = 1'b0,
    localparam int unsigned RW            = $clog2(ROWS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [3:0]      brightness,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic            frame_strobe,
    output logic [RW-1:0]   row_idx,
    output logic [ROWS-1:0] rows,
    output logic [COLS-1:0] cols
);

    localparam int unsigned     CW        = $clog2(ROW_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] ROWS_OFF  = {ROWS{ROW_ACTIVE_LOW}};
    localparam logic [COLS-1:0] COLS_OFF  = {COLS{COL_ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state;
    logic [CW-1:0]   cycle_cnt;
    logic [CW-1:0]   cycle_cnt_nxt;
    logic [RW-1:0]   row_nxt;
    logic            pending;
    logic            pending_nxt;
    logic            front_sel;
    logic            pwm_open;
    logic            wr_ok;
    logic [COLS-1:0] front_row;
    logic [ROWS-1:0] rows_nxt;
    logic [COLS-1:0] cols_nxt;
    logic [COLS-1:0] buf_a [ROWS];
    logic [COLS-1:0] buf_b [ROWS];

    // State decode, scan counters, swap arbitration and next driver levels
    always_comb begin
        state         = IDLE;
        cycle_cnt_nxt = '0;
        row_nxt       = '0;
        frame_strobe  = 1'b0;
        swap_ack      = 1'b0;
        pending_nxt   = pending;
        rows_nxt      = ROWS_OFF;
        cols_nxt      = COLS_OFF;
        wr_ok         = 32'(wr_row) < ROWS;
        front_row     = front_sel ? buf_b[row_idx] : buf_a[row_idx];
        pwm_open      = (brightness == 4'hF) || (cycle_cnt[3:0] < brightness);

        if (enable) begin
            state = (cycle_cnt < BLANK_END) ? BLANK : DRIVE;
            if (cycle_cnt == CNT_LAST) begin
                row_nxt      = (row_idx == ROW_LAST) ? '0 : row_idx + RW'(1);
                frame_strobe = (row_idx == ROW_LAST);
            end else begin
                cycle_cnt_nxt = cycle_cnt + CW'(1);
                row_nxt       = row_idx;
            end
        end

        // A reset edge wins over a swap, so the ack is masked while reset is low
        swap_ack    = reset_n && pending && ((state == IDLE) || frame_strobe);
        pending_nxt = swap_req || (pending && !swap_ack);

        if (state == DRIVE) begin
            rows_nxt = ROWS_OFF ^ (ROWS'(1) << row_idx);
            cols_nxt = COLS_OFF ^ (front_row & {COLS{pwm_open}});
        end
    end

    // Counters, buffers and registered drivers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            row_idx   <= '0;
            pending   <= 1'b0;
            front_sel <= 1'b0;
            rows      <= ROWS_OFF;
            cols      <= COLS_OFF;
            for (int r = 0; r < int'(ROWS); r++) begin
                buf_a[r] <= '0;
                buf_b[r] <= '0;
            end
        end else begin
            cycle_cnt <= cycle_cnt_nxt;
            row_idx   <= row_nxt;
            pending   <= pending_nxt;
            rows      <= rows_nxt;
            cols      <= cols_nxt;
            // The write targets the pre-swap back buffer, so it shows in the new front
            if (wr_en && wr_ok) begin
                if (front_sel) buf_a[wr_row] <= wr_data;
                else           buf_b[wr_row] <= wr_data;
            end
            if (swap_ack) front_sel <= !front_sel;
        end
    end

endmodule
